// File: rtl/reg_file_mp_pkg.sv
// Shared widths and types for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W    = 32;
    localparam int unsigned RF_ADDR_W    = 5;
    localparam int unsigned RF_NUM_RD    = 2;
    localparam int unsigned RF_ZERO_ADDR = 0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file: write port, read ports, scoreboard.
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NUM_RD = RF_NUM_RD
);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic [2**ADDR_W-1:0]     pend_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, pend_set, pend_addr,
        input  rd_data, rd_pend, pend_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, pend_set, pend_addr,
        output rd_data, rd_pend, pend_vec
    );

endinterface

// File: rtl/reg_file_mp_pend_tracker.sv
// Per-register pending scoreboard: a set (load issued) beats a same-address clear (writeback).
module rf_pend_tracker
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr,
    input  logic [ADDR_W-1:0]    clr_addr,
    output logic [2**ADDR_W-1:0] pend_vec,
    output logic [2**ADDR_W-1:0] pend_next_c
);

    // Clear first so a same-address set overrides it; entry 0 can never be pending.
    always_comb begin
        pend_next_c = pend_vec;
        if (clr) pend_next_c[clr_addr] = 1'b0;
        if (set) pend_next_c[set_addr] = 1'b1;
        if (ZERO_REG) pend_next_c[RF_ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_vec <= '0;
        else        pend_vec <= pend_next_c;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: one write port, NUM_RD registered read ports with
// write-first bypass, optional hard-wired zero register and a load scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = RF_NUM_RD,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_mp_if.slave bus
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("reg_file_mp: NUM_RD must be in 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pendNext;
    logic              wrOk;
    logic [DATA_W-1:0] rdDataQ [NUM_RD];
    logic              rdPendQ [NUM_RD];

    always_comb begin
        wrOk = bus.wr_en && !(ZERO_REG && bus.wr_addr == ADDR_W'(RF_ZERO_ADDR));
    end

    // Storage array; a write to the zero register never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (wrOk) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    rf_pend_tracker #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_pend (
        .clk         (clk),
        .rst_n       (rst_n),
        .set         (bus.pend_set),
        .set_addr    (bus.pend_addr),
        .clr         (bus.wr_en),
        .clr_addr    (bus.wr_addr),
        .pend_vec    (bus.pend_vec),
        .pend_next_c (pendNext)
    );

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [ADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0] srcData;
        logic              srcPend;

        // Write-first bypass and post-update pending view; zero register overrides both.
        always_comb begin
            rdAddr  = bus.rd_addr[p*ADDR_W +: ADDR_W];
            srcData = mem[rdAddr];
            srcPend = pendNext[rdAddr];
            if (wrOk && bus.wr_addr == rdAddr) srcData = bus.wr_data;
            if (ZERO_REG && rdAddr == ADDR_W'(RF_ZERO_ADDR)) begin
                srcData = '0;
                srcPend = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdDataQ[p] <= '0;
                rdPendQ[p] <= 1'b0;
            end else if (bus.rd_en[p]) begin
                rdDataQ[p] <= srcData;
                rdPendQ[p] <= srcPend;
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_pend = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            bus.rd_data[p*DATA_W +: DATA_W] = rdDataQ[p];
            bus.rd_pend[p]                  = rdPendQ[p];
        end
    end

endmodule
